// File: rtl/hbm_health_monitor.sv
// rtl/hbm_health_monitor.sv - per-device HBM calibration and thermal health monitor
// The optional debounced temperature warning is built only when HBM_HEALTH_TEMP_WARN_EN is defined.
module hbm_health_monitor #(
  parameter int unsigned NUM_DEV         = 2,
  parameter logic [31:0] CAL_TIMEOUT_CYC = 32'd50_000_000,
  parameter logic [2:0]  TEMP_WARN_LVL   = 3'd4,
  parameter logic [15:0] TEMP_DEBOUNCE   = 16'd1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_DEV-1:0] cal_success,
  input  logic [NUM_DEV-1:0] cal_fail,
  input  logic [NUM_DEV-1:0] cattrip,
  input  logic [2:0]         temp [NUM_DEV],
  input  logic [NUM_DEV-1:0] clear_fault,
  output logic [NUM_DEV-1:0] dev_ready,
  output logic [NUM_DEV-1:0] dev_fault,
  output logic [1:0]         fault_code [NUM_DEV],
  output logic [NUM_DEV-1:0] temp_warn,
  output logic               irq
);

  typedef enum logic [1:0] {
    ST_CAL_WAIT = 2'd0,
    ST_READY    = 2'd1,
    ST_FAULT    = 2'd2
  } state_e;

  logic [NUM_DEV-1:0] succ_m_q, succ_s_q;
  logic [NUM_DEV-1:0] fail_m_q, fail_s_q;
  logic [NUM_DEV-1:0] trip_m_q, trip_s_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      succ_m_q <= '0;
      succ_s_q <= '0;
      fail_m_q <= '0;
      fail_s_q <= '0;
      trip_m_q <= '0;
      trip_s_q <= '0;
    end else begin
      succ_m_q <= cal_success;
      succ_s_q <= succ_m_q;
      fail_m_q <= cal_fail;
      fail_s_q <= fail_m_q;
      trip_m_q <= cattrip;
      trip_s_q <= trip_m_q;
    end
  end

  for (genvar d = 0; d < NUM_DEV; d++) begin : g_dev
    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  code_q, code_d;

    // Fault causes are checked in priority order; the code is latched only on FAULT entry.
    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      code_d  = code_q;
      unique case (state_q)
        ST_CAL_WAIT: begin
          cnt_d = (cnt_q == CAL_TIMEOUT_CYC) ? cnt_q : cnt_q + 32'd1;
          if (trip_s_q[d]) begin
            state_d = ST_FAULT;
            code_d  = 2'd3;
          end else if (fail_s_q[d]) begin
            state_d = ST_FAULT;
            code_d  = 2'd1;
          end else if (succ_s_q[d]) begin
            state_d = ST_READY;
          end else if (cnt_q == CAL_TIMEOUT_CYC) begin
            state_d = ST_FAULT;
            code_d  = 2'd2;
          end
        end
        ST_READY: begin
          if (trip_s_q[d]) begin
            state_d = ST_FAULT;
            code_d  = 2'd3;
          end else if (fail_s_q[d] || !succ_s_q[d]) begin
            state_d = ST_FAULT;
            code_d  = 2'd1;
          end
        end
        ST_FAULT: begin
          if (clear_fault[d] && !trip_s_q[d]) begin
            state_d = ST_CAL_WAIT;
            code_d  = 2'd0;
          end
        end
        default: begin
          state_d = ST_CAL_WAIT;
          code_d  = 2'd0;
        end
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_CAL_WAIT;
        cnt_q   <= '0;
        code_q  <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        code_q  <= code_d;
      end
    end

    assign dev_ready[d]  = (state_q == ST_READY);
    assign dev_fault[d]  = (state_q == ST_FAULT);
    assign fault_code[d] = code_q;

`ifdef HBM_HEALTH_TEMP_WARN_EN
    logic [2:0]  temp_m_q, temp_s_q;
    logic [15:0] deb_q, deb_d;

    always_comb begin
      deb_d = '0;
      if (temp_s_q >= TEMP_WARN_LVL) begin
        deb_d = (deb_q == TEMP_DEBOUNCE) ? deb_q : deb_q + 16'd1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        temp_m_q <= '0;
        temp_s_q <= '0;
        deb_q    <= '0;
      end else begin
        temp_m_q <= temp[d];
        temp_s_q <= temp_m_q;
        deb_q    <= deb_d;
      end
    end

    assign temp_warn[d] = (deb_q == TEMP_DEBOUNCE);
`else
    logic unused_temp;
    assign unused_temp  = ^temp[d];
    assign temp_warn[d] = 1'b0;
`endif
  end

  // Edge detection against delayed copies so reset exit never looks like a new event.
  logic [NUM_DEV-1:0] fault_dly_q;
  logic               irq_q, irq_d;

`ifdef HBM_HEALTH_TEMP_WARN_EN
  logic [NUM_DEV-1:0] warn_dly_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warn_dly_q <= '0;
    end else begin
      warn_dly_q <= temp_warn;
    end
  end

  assign irq_d = (|(dev_fault & ~fault_dly_q)) | (|(temp_warn & ~warn_dly_q));
`else
  assign irq_d = |(dev_fault & ~fault_dly_q);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_dly_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      fault_dly_q <= dev_fault;
      irq_q       <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_hbm_health_monitor.sv
// tb/tb_hbm_health_monitor.sv - scoreboard bench for hbm_health_monitor
module tb_hbm_health_monitor;
  localparam int ND = 2;
  localparam int S_RDY = 0, S_FLT = 1, S_CODE = 2, S_WARN = 3, S_IRQ = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [ND-1:0] cal_success, cal_fail, cattrip, clear_fault;
  logic [2:0]    temp [ND];
  logic [ND-1:0] dev_ready, dev_fault, temp_warn;
  logic [1:0]    fault_code [ND];
  logic          irq;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int r, rr, r2, t;

  typedef struct {
    int    at;
    int    sig;
    int    dev;
    int    val;
    string name;
  } exp_t;
  exp_t sb[$];

  hbm_health_monitor #(
    .NUM_DEV(ND),
    .CAL_TIMEOUT_CYC(32'd100),
    .TEMP_WARN_LVL(3'd4),
    .TEMP_DEBOUNCE(16'd8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cal_success(cal_success),
    .cal_fail(cal_fail),
    .cattrip(cattrip),
    .temp(temp),
    .clear_fault(clear_fault),
    .dev_ready(dev_ready),
    .dev_fault(dev_fault),
    .fault_code(fault_code),
    .temp_warn(temp_warn),
    .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
    end
  endtask

  task automatic ex(input int at, input int sig, input int dev, input int val, input string nm);
    exp_t e;
    e.at = at; e.sig = sig; e.dev = dev; e.val = val; e.name = nm;
    sb.push_back(e);
  endtask

  function automatic int sample(input int sig, input int dev);
    case (sig)
      S_RDY:   return int'(dev_ready[dev]);
      S_FLT:   return int'(dev_fault[dev]);
      S_CODE:  return int'(fault_code[dev]);
      S_WARN:  return int'(temp_warn[dev]);
      default: return int'(irq);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        chk(sb[i].name, sample(sb[i].sig, sb[i].dev), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic at_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, int'(dev_ready), 0);
    chk({tag, "_fault"}, int'(dev_fault), 0);
    chk({tag, "_code0"}, int'(fault_code[0]), 0);
    chk({tag, "_code1"}, int'(fault_code[1]), 0);
    chk({tag, "_warn"}, int'(temp_warn), 0);
    chk({tag, "_irq"}, int'(irq), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cal_success = '0; cal_fail = '0; cattrip = '0; clear_fault = '0;
    temp[0] = 3'd0; temp[1] = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    r = cyc;
    reset = 1'b0;
    rr = r + 320;
    r2 = rr + 52;
    t = r2 + 110;

    ex(r+12, S_RDY, 0, 0, "succ_ready_early");
    ex(r+13, S_RDY, 0, 1, "succ_ready");
    ex(r+13, S_IRQ, 0, 0, "succ_no_irq");
    ex(r+14, S_IRQ, 0, 0, "succ_no_irq2");
    ex(r+100, S_FLT, 1, 0, "tmo_early");
    ex(r+101, S_FLT, 1, 1, "tmo_fault");
    ex(r+101, S_CODE, 1, 2, "tmo_code");
    ex(r+101, S_IRQ, 0, 0, "tmo_irq_early");
    ex(r+102, S_IRQ, 0, 1, "tmo_irq");
    ex(r+103, S_IRQ, 0, 0, "tmo_irq_once");
    ex(r+110, S_FLT, 1, 1, "tmo_sticky");
    ex(r+111, S_FLT, 1, 0, "clr_fault");
    ex(r+111, S_CODE, 1, 0, "clr_code");
    ex(r+211, S_FLT, 1, 0, "tmo2_early");
    ex(r+212, S_FLT, 1, 1, "tmo2_fault");
    ex(r+212, S_CODE, 1, 2, "tmo2_code");
    ex(r+213, S_IRQ, 0, 1, "tmo2_irq");
    ex(r+232, S_RDY, 0, 1, "trip_ready_early");
    ex(r+232, S_CODE, 0, 0, "trip_code_early");
    ex(r+233, S_FLT, 0, 1, "trip_fault");
    ex(r+233, S_CODE, 0, 3, "trip_code");
    ex(r+233, S_RDY, 0, 0, "trip_not_ready");
    ex(r+234, S_IRQ, 0, 1, "trip_irq");
    ex(r+235, S_IRQ, 0, 0, "trip_irq_once");
    ex(r+241, S_FLT, 0, 1, "trip_clr_ignored");
    ex(r+241, S_CODE, 0, 3, "trip_clr_code");
    ex(r+242, S_IRQ, 0, 0, "trip_clr_no_irq");
    ex(r+245, S_FLT, 0, 1, "trip_still_fault");
    ex(r+260, S_FLT, 0, 1, "trip_low_sticky");
    ex(r+261, S_FLT, 0, 0, "trip_clr_ok");
    ex(r+261, S_CODE, 0, 0, "trip_clr_code0");
    ex(r+261, S_RDY, 0, 0, "trip_clr_calwait");
    ex(r+262, S_RDY, 0, 1, "trip_recal_ready");
    ex(r+262, S_IRQ, 0, 0, "trip_recal_no_irq");
    ex(r+271, S_FLT, 1, 0, "both_clr");
    ex(r+271, S_CODE, 1, 0, "both_clr_code");
    ex(r+272, S_RDY, 1, 0, "both_rdy_a");
    ex(r+272, S_FLT, 1, 0, "both_flt_early");
    ex(r+273, S_RDY, 1, 0, "both_rdy_b");
    ex(r+273, S_FLT, 1, 1, "both_fault");
    ex(r+273, S_CODE, 1, 1, "both_code");
    ex(r+274, S_IRQ, 0, 1, "both_irq");
    ex(r+280, S_RDY, 1, 0, "both_rdy_c");
    ex(r+303, S_FLT, 0, 1, "lost_fault");
    ex(r+303, S_CODE, 0, 1, "lost_code");
    ex(r+304, S_IRQ, 0, 1, "lost_irq");
    ex(r+309, S_FLT, 0, 1, "pre_rst_f0");
    ex(r+309, S_FLT, 1, 1, "pre_rst_f1");
    ex(r+309, S_CODE, 1, 1, "pre_rst_c1");
    ex(rr+49, S_FLT, 0, 0, "cw_f0");
    ex(rr+49, S_FLT, 1, 0, "cw_f1");
    ex(r2+1, S_IRQ, 0, 0, "rst_exit_no_irq");
    ex(r2+100, S_FLT, 0, 0, "rst_tmo_early");
    ex(r2+101, S_FLT, 0, 1, "rst_tmo_f0");
    ex(r2+101, S_FLT, 1, 1, "rst_tmo_f1");
    ex(r2+101, S_CODE, 0, 2, "rst_tmo_c0");
    ex(r2+101, S_CODE, 1, 2, "rst_tmo_c1");
    ex(r2+102, S_IRQ, 0, 1, "rst_tmo_irq");
    ex(r2+103, S_IRQ, 0, 0, "rst_tmo_irq_once");
`ifdef HBM_HEALTH_TEMP_WARN_EN
    ex(t+9, S_WARN, 0, 0, "warn_run7_a");
    ex(t+10, S_WARN, 0, 0, "warn_run7_b");
    ex(t+17, S_WARN, 0, 0, "warn_early");
    ex(t+18, S_WARN, 0, 1, "warn_set");
    ex(t+18, S_IRQ, 0, 0, "warn_irq_early");
    ex(t+19, S_IRQ, 0, 1, "warn_irq");
    ex(t+20, S_IRQ, 0, 0, "warn_irq_once");
    ex(t+20, S_WARN, 1, 0, "warn_dev1_off");
`else
    ex(t+18, S_WARN, 0, 0, "nowarn_0");
    ex(t+18, S_WARN, 1, 0, "nowarn_1");
    ex(t+19, S_IRQ, 0, 0, "nowarn_irq");
    ex(t+24, S_WARN, 0, 0, "nowarn_late");
`endif

    at_cyc(r+10);  cal_success[0] = 1'b1;
    at_cyc(r+110); clear_fault[1] = 1'b1;
    at_cyc(r+111); clear_fault[1] = 1'b0;
    at_cyc(r+230); cattrip[0] = 1'b1;
    at_cyc(r+240); clear_fault[0] = 1'b1;
    at_cyc(r+241); clear_fault[0] = 1'b0;
    at_cyc(r+250); cattrip[0] = 1'b0;
    at_cyc(r+260); clear_fault[0] = 1'b1;
    at_cyc(r+261); clear_fault[0] = 1'b0;
    at_cyc(r+270); clear_fault[1] = 1'b1; cal_success[1] = 1'b1; cal_fail[1] = 1'b1;
    at_cyc(r+271); clear_fault[1] = 1'b0;
    at_cyc(r+300); cal_success = '0; cal_fail = '0;
    at_cyc(r+310); reset = 1'b1;
    #1;
    chk_zero("midrst");
    at_cyc(rr);    reset = 1'b0;
    at_cyc(rr+50); reset = 1'b1;
    #1;
    chk_zero("cwrst");
    at_cyc(r2);    reset = 1'b0;
    at_cyc(t);     temp[0] = 3'd5;
`ifndef HBM_HEALTH_TEMP_WARN_EN
    temp[1] = 3'd7;
`endif
    at_cyc(t+7);   temp[0] = 3'd3;
    at_cyc(t+8);   temp[0] = 3'd5;
    at_cyc(t+26);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
